// File: rtl/alu_pkg.sv
// Shared ALU/status definitions: flag instruction encoding, P bit indices, upd_mask bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    FLAG_NOP = 3'd0,
    FLAG_CLC = 3'd1,
    FLAG_SEC = 3'd2,
    FLAG_CLI = 3'd3,
    FLAG_SEI = 3'd4,
    FLAG_CLV = 3'd5,
    FLAG_CLD = 3'd6,
    FLAG_SED = 3'd7
  } flag_op_e;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam int UPD_C = 0;
  localparam int UPD_Z = 1;
  localparam int UPD_V = 2;
  localparam int UPD_N = 3;

endpackage

// File: rtl/status_reg_if.sv
// Status register bus: ALU/decoder controls in, P byte and ALU feedback out.
interface status_reg_if;
  logic [7:0] alu_y;
  logic       alu_v;
  logic       alu_c;
  logic       upd_en;
  logic [3:0] upd_mask;
  logic [2:0] flag_op;
  logic       bit_en;
  logic       load_en;
  logic [7:0] load_data;
  logic       int_set;
  logic       instr_done;
  logic       push_brk;
  logic [7:0] p;
  logic [7:0] p_push;
  logic       carry;
  logic       daa;
  logic       irq_mask;

  modport master (
    output alu_y, alu_v, alu_c, upd_en, upd_mask, flag_op, bit_en,
           load_en, load_data, int_set, instr_done, push_brk,
    input  p, p_push, carry, daa, irq_mask
  );

  modport slave (
    input  alu_y, alu_v, alu_c, upd_en, upd_mask, flag_op, bit_en,
           load_en, load_data, int_set, instr_done, push_brk,
    output p, p_push, carry, daa, irq_mask
  );
endinterface

// File: rtl/status_reg.sv
// 6502 processor status register P with boundary-delayed interrupt mask.
// Define STATUS_DECIMAL_EN to feed D to the ALU; otherwise daa is tied 0 (2A03 style).
module status_reg
  import alu_pkg::*;
(
  input logic         clk,
  input logic         rst,
  status_reg_if.slave bus
);

  logic n_q, n_d, v_q, v_d, d_q, d_d, i_q, i_d, z_q, z_d, c_q, c_d;
  logic irq_mask_q, irq_mask_d;
  logic     y_zero;
  flag_op_e op;

  assign y_zero = (bus.alu_y == 8'h00);
  assign op     = flag_op_e'(bus.flag_op);

  always_comb begin
    n_d = n_q;
    v_d = v_q;
    z_d = z_q;
    c_d = c_q;
    if (bus.load_en) begin
      n_d = bus.load_data[P_N];
      v_d = bus.load_data[P_V];
      z_d = bus.load_data[P_Z];
      c_d = bus.load_data[P_C];
    end else if (bus.bit_en) begin
      // BIT takes N/V from memory and leaves C alone, regardless of upd_mask
      n_d = bus.load_data[P_N];
      v_d = bus.load_data[P_V];
      z_d = y_zero;
    end else begin
      if (bus.upd_en && bus.upd_mask[UPD_N]) n_d = bus.alu_y[7];
      if (bus.upd_en && bus.upd_mask[UPD_Z]) z_d = y_zero;
      if (bus.upd_en && bus.upd_mask[UPD_V]) v_d = bus.alu_v;
      else if (op == FLAG_CLV)               v_d = 1'b0;
      if (bus.upd_en && bus.upd_mask[UPD_C]) c_d = bus.alu_c;
      else if (op == FLAG_CLC)               c_d = 1'b0;
      else if (op == FLAG_SEC)               c_d = 1'b1;
    end
  end

  always_comb begin
    d_d = d_q;
    if (bus.load_en)           d_d = bus.load_data[P_D];
    else if (op == FLAG_CLD)   d_d = 1'b0;
    else if (op == FLAG_SED)   d_d = 1'b1;
  end

  always_comb begin
    i_d = i_q;
    if (bus.int_set)           i_d = 1'b1;
    else if (bus.load_en)      i_d = bus.load_data[P_I];
    else if (op == FLAG_CLI)   i_d = 1'b0;
    else if (op == FLAG_SEI)   i_d = 1'b1;
  end

  // Mask samples the pre-edge I, giving the one-instruction CLI/SEI/PLP delay
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (bus.int_set)         irq_mask_d = 1'b1;
    else if (bus.instr_done) irq_mask_d = i_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      d_q        <= 1'b0;
      i_q        <= 1'b1;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      irq_mask_q <= 1'b1;
    end else begin
      n_q        <= n_d;
      v_q        <= v_d;
      d_q        <= d_d;
      i_q        <= i_d;
      z_q        <= z_d;
      c_q        <= c_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  assign bus.p        = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign bus.p_push   = {n_q, v_q, 1'b1, bus.push_brk, d_q, i_q, z_q, c_q};
  assign bus.carry    = c_q;
  assign bus.irq_mask = irq_mask_q;
`ifdef STATUS_DECIMAL_EN
  assign bus.daa      = d_q;
`else
  assign bus.daa      = 1'b0;
`endif

endmodule

// File: tb/tb_status_reg.sv
// Directed-vector bench for status_reg; expected P values are hand-computed.
module tb_status_reg;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic exp_daa_d1;

  status_reg_if bus ();

  status_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef STATUS_DECIMAL_EN
  initial exp_daa_d1 = 1'b1;
`else
  initial exp_daa_d1 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alu_y      = 8'h00;
    bus.alu_v      = 1'b0;
    bus.alu_c      = 1'b0;
    bus.upd_en     = 1'b0;
    bus.upd_mask   = 4'b0000;
    bus.flag_op    = FLAG_NOP;
    bus.bit_en     = 1'b0;
    bus.load_en    = 1'b0;
    bus.load_data  = 8'h00;
    bus.int_set    = 1'b0;
    bus.instr_done = 1'b0;
    bus.push_brk   = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst = 1'b1;
    #12;
    chk("rst_p", bus.p, 8'h34);
    chk("rst_irq_mask", {7'd0, bus.irq_mask}, 8'h01);
    chk("rst_carry", {7'd0, bus.carry}, 8'h00);
    chk("rst_daa", {7'd0, bus.daa}, 8'h00);
    chk("rst_push_brk1", bus.p_push, 8'h34);
    bus.push_brk = 1'b0;
    #1;
    chk("rst_push_brk0", bus.p_push, 8'h24);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // ALU commit under mask 1011: Z=1 C=1 N=0, V untouched
    bus.alu_y = 8'h00; bus.alu_v = 1'b1; bus.alu_c = 1'b1;
    bus.upd_en = 1'b1; bus.upd_mask = 4'b1011;
    tick();
    chk("commit_mask_p", bus.p, 8'h37);
    chk("commit_carry", {7'd0, bus.carry}, 8'h01);

    // upd_mask without upd_en must not commit
    bus.alu_y = 8'h80; bus.alu_v = 1'b1; bus.alu_c = 1'b0; bus.upd_mask = 4'b1111;
    tick();
    chk("no_upd_en_hold", bus.p, 8'h37);

    // load beats CLC
    bus.load_en = 1'b1; bus.load_data = 8'hFF; bus.flag_op = FLAG_CLC;
    tick();
    chk("load_vs_clc_p", bus.p, 8'hFF);
    chk("load_vs_clc_carry", {7'd0, bus.carry}, 8'h01);
    chk("load_d_daa", {7'd0, bus.daa}, {7'd0, exp_daa_d1});
    chk("load_irq_mask_hold", {7'd0, bus.irq_mask}, 8'h01);

    // load C3: bits 5:4 ignored; N V Z C set, D I clear
    bus.load_en = 1'b1; bus.load_data = 8'hC3;
    tick();
    chk("load_c3_p", bus.p, 8'hF3);
    bus.push_brk = 1'b0;
    #1;
    chk("push_brk0", bus.p_push, 8'hE3);
    bus.push_brk = 1'b1;
    #1;
    chk("push_brk1", bus.p_push, 8'hF3);

    // SEI then CLI with instr_done: mask takes pre-edge I
    bus.flag_op = FLAG_SEI;
    tick();
    chk("sei_p", bus.p, 8'hF7);
    bus.flag_op = FLAG_CLI; bus.instr_done = 1'b1;
    tick();
    chk("cli_p", bus.p, 8'hF3);
    chk("cli_irq_mask_delayed", {7'd0, bus.irq_mask}, 8'h01);
    bus.flag_op = FLAG_NOP;
    tick();
    chk("nop_no_done_irq_mask", {7'd0, bus.irq_mask}, 8'h01);
    bus.instr_done = 1'b1;
    tick();
    chk("next_done_irq_mask", {7'd0, bus.irq_mask}, 8'h00);

    // int_set overrides CLI and instr_done
    bus.int_set = 1'b1; bus.flag_op = FLAG_CLI; bus.instr_done = 1'b1;
    tick();
    chk("int_set_p", bus.p, 8'hF7);
    chk("int_set_irq_mask", {7'd0, bus.irq_mask}, 8'h01);

    // BIT: N=0 V=1 Z=1, C unchanged even with upd_en asserted
    bus.bit_en = 1'b1; bus.load_data = 8'h40; bus.alu_y = 8'h00;
    bus.upd_en = 1'b1; bus.upd_mask = 4'b1111; bus.alu_c = 1'b0; bus.alu_v = 1'b0;
    tick();
    chk("bit_p", bus.p, 8'h77);

    bus.flag_op = FLAG_CLV;
    tick();
    chk("clv_p", bus.p, 8'h37);
    bus.flag_op = FLAG_CLC;
    tick();
    chk("clc_p", bus.p, 8'h36);
    chk("clc_carry", {7'd0, bus.carry}, 8'h00);
    bus.flag_op = FLAG_SEC;
    tick();
    chk("sec_carry", {7'd0, bus.carry}, 8'h01);

    bus.flag_op = FLAG_SED;
    tick();
    chk("sed_p", bus.p, 8'h3F);
    chk("sed_daa", {7'd0, bus.daa}, {7'd0, exp_daa_d1});
    bus.flag_op = FLAG_CLD;
    tick();
    chk("cld_p", bus.p, 8'h37);
    chk("cld_daa", {7'd0, bus.daa}, 8'h00);

    // N-only commit: Z and C kept
    bus.upd_en = 1'b1; bus.upd_mask = 4'b1000; bus.alu_y = 8'h80; bus.alu_c = 1'b0;
    tick();
    chk("n_only_p", bus.p, 8'hB7);

    // V commit wins over CLV
    bus.upd_en = 1'b1; bus.upd_mask = 4'b0100; bus.alu_v = 1'b1; bus.flag_op = FLAG_CLV;
    tick();
    chk("v_upd_over_clv", bus.p, 8'hF7);

    // Asynchronous reset mid-run, between clock edges
    bus.load_en = 1'b1; bus.load_data = 8'hCB;
    tick();
    chk("pre_rst_p", bus.p, 8'hFB);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_p", bus.p, 8'h34);
    chk("async_rst_irq_mask", {7'd0, bus.irq_mask}, 8'h01);
    chk("async_rst_daa", {7'd0, bus.daa}, 8'h00);
    chk("async_rst_carry", {7'd0, bus.carry}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bus.flag_op = FLAG_SEC;
    tick();
    chk("post_rst_sec", bus.p, 8'h35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/status_reg.md
# status_reg

Processor status register (P) for the 6502 core, sitting directly downstream of the ALU. Captures ALU results into N/V/Z/C under per-flag write masks, executes the flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED), loads P from the data bus (PLP/RTI), and forms the pushed P byte (PHP/BRK/IRQ/NMI). Feeds carry-in and decimal-enable back to the ALU, and provides the instruction-boundary-delayed interrupt mask to the interrupt logic.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- alu_y  in  8  ALU result; source of N (bit 7) and Z (==0)
- alu_v  in  1  ALU signed overflow
- alu_c  in  1  ALU carry out
- upd_en  in  1  commit ALU flags this cycle
- upd_mask  in  4  per-flag commit enable: [3]=N [2]=V [1]=Z [0]=C
- flag_op  in  3  0 NOP, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED
- bit_en  in  1  BIT instruction: N<=load_data[7], V<=load_data[6], Z<=(alu_y==0)
- load_en  in  1  load P from load_data (PLP/RTI)
- load_data  in  8  data bus byte
- int_set  in  1  interrupt entry: set I
- instr_done  in  1  last cycle of current instruction
- push_brk  in  1  B value for p_push (1 for PHP/BRK, 0 for IRQ/NMI)
- p  out  8  {N,V,1,1,D,I,Z,C}
- p_push  out  8  {N,V,1,push_brk,D,I,Z,C}
- carry  out  1  C flag, to ALU carry in
- daa  out  1  decimal enable, to ALU
- irq_mask  out  1  I as sampled at the last instruction boundary

## Operation
- Six stored bits: N V D I Z C. Bits 5 and 4 are not stored; p reads them as 1; p_push bit 4 = push_brk.
- All state updates occur on the rising edge of clk; combinational outputs follow the registers.
- N/V/Z/C priority, per bit: load_en > bit_en > (upd_en & upd_mask bit) > flag_op (C via CLC/SEC, V via CLV) > hold.
- D priority: load_en > flag_op (CLD/SED) > hold.
- I priority: int_set > load_en > flag_op (CLI/SEI) > hold.
- load_en ignores load_data[5:4].
- bit_en ignores upd_mask and leaves C unchanged.
- irq_mask: on instr_done, irq_mask <= registered I value before that edge's update. This gives the 6502 one-instruction delay after CLI/SEI/PLP.
- int_set also forces irq_mask <= 1 on the same edge, overriding instr_done.
- Reset: N=V=D=Z=C=0, I=1, irq_mask=1. This gives p=8'h34, carry=0, daa=0.

## Timing
- Flag writes are visible on p/carry/daa the cycle after the qualifying edge; there is no combinational bypass.
- p_push is combinational from the registers, so the pushed byte reflects the state before any same-cycle update.
- Simultaneous load_en and flag_op: load_en wins on every bit it drives.
- Simultaneous int_set and CLI: I=1.
- Reset asserted mid-instruction: all state returns to reset values immediately (asynchronous). The first edge after deassertion is processed normally.
- irq_mask changes only on instr_done, int_set or reset.

## Configuration
- STATUS_DECIMAL_EN defined: daa = D.
- STATUS_DECIMAL_EN undefined (2A03 style):
  - D is still stored, loaded and pushed.
  - daa is tied 0, so the ALU always adds in binary.

## Structure
- Shared package alu_pkg holds:
  - the flag_op enum (FLAG_NOP…FLAG_SED)
  - P bit-index constants (P_C=0 … P_N=7)
  - upd_mask bit positions
- The ALU and decoder import the same package.
- Single module. No sub-module is warranted; next-state logic is one always_comb per bit group plus one always_ff.

## Test plan
- Reset check: pulse rst mid-run → p=8'h34, irq_mask=1, daa=0, carry=0 asynchronously.
- ALU commit with mask: alu_y=8'h00, alu_v=1, alu_c=1, upd_en=1, upd_mask=4'b1011 → next cycle Z=1, C=1, N=0, V unchanged.
- Load versus flag op: load_en=1, load_data=8'hFF, flag_op=CLC in the same cycle → p=8'hFF, C=1.
- Interrupt-mask delay: execute CLI, then instr_done on the same edge → irq_mask stays 1. On the next instr_done, irq_mask=0.
- Push byte and BIT:
  - With P=8'hC3 and push_brk=0 → p_push=8'hE3.
  - bit_en with load_data=8'h40 and alu_y=0 → N=0, V=1, Z=1.
- Decimal configuration: SED → daa=1 with STATUS_DECIMAL_EN; daa=0 without it while p[3]=1 in both builds.
